// File: rtl/dccm_pkg.sv
// rtl/dccm_pkg.sv - shared state type, geometry defaults and address-decode helpers for the banked DCCM
package dccm_pkg;

   localparam int DCCM_DATA_W    = 39;
   localparam int DCCM_BYTE_BITS = 2;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      SECOND
   } dccm_state_t;

   // Results are 32 bits wide; callers cast down to their bank/row width.
   function automatic logic [31:0] bank_of(input logic [31:0] addr, input int byte_bits,
                                           input int bank_bits);
      return (addr >> byte_bits) & ((32'd1 << bank_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] row_of(input logic [31:0] addr, input int byte_bits,
                                          input int bank_bits);
      return addr >> (byte_bits + bank_bits);
   endfunction

endpackage

// File: rtl/dccm_sram_bank.sv
// rtl/dccm_sram_bank.sv - single-port synchronous SRAM bank with registered read and no array reset
module dccm_sram_bank
   import dccm_pkg::*;
#(
   parameter int DEPTH    = 4096,
   parameter int ROW_BITS = 12,
   parameter int DATA_W   = DCCM_DATA_W
) (
   input  logic              clock,
   input  logic              en,
   input  logic              we,
   input  logic [ROW_BITS-1:0] row,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (en) begin
         if (we) mem[row] <= wdata;
         else    rdata    <= mem[row];
      end
   end

endmodule

// File: rtl/dccm_banked_mem.sv
// rtl/dccm_banked_mem.sv - banked DCCM with request handshake, same-bank conflict serialisation,
// post-reset zero scrub and read-response pipeline
module dccm_banked_mem
   import dccm_pkg::*;
#(
   parameter int ADDR_BITS = 16,
   parameter int DATA_W    = DCCM_DATA_W,
   parameter int BYTE_BITS = DCCM_BYTE_BITS,
   parameter int NUM_BANKS = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_req_valid,
   output logic                 io_req_ready,
   input  logic                 io_wren,
   input  logic                 io_rden,
   input  logic [ADDR_BITS-1:0] io_addr_lo,
   input  logic [ADDR_BITS-1:0] io_addr_hi,
   input  logic [DATA_W-1:0]    io_wr_data_lo,
   input  logic [DATA_W-1:0]    io_wr_data_hi,
   output logic                 io_rd_valid,
   output logic [DATA_W-1:0]    io_rd_data_lo,
   output logic [DATA_W-1:0]    io_rd_data_hi,
   output logic                 io_init_done
);

   localparam int BANK_BITS = $clog2(NUM_BANKS);
   localparam int ROW_BITS  = ADDR_BITS - BYTE_BITS - BANK_BITS;
   localparam int DEPTH     = 1 << ROW_BITS;

   typedef logic [BANK_BITS-1:0] bank_t;
   typedef logic [ROW_BITS-1:0]  row_t;

   dccm_state_t       state, state_nxt;
   row_t              scrub_row;
   bank_t             bank_lo, bank_hi;
   row_t              row_lo, row_hi;
   logic              accept, do_wr, do_rd, conflict;

   bank_t             hold_bank;
   row_t              hold_row;
   logic [DATA_W-1:0] hold_data;
   logic              hold_wr, hold_rd;

   logic              rsp_valid, lo_live, cap_pending;
   bank_t             lo_sel, hi_sel;
   logic [DATA_W-1:0] held_lo, held_hi;

   logic              bank_en    [NUM_BANKS];
   logic              bank_we    [NUM_BANKS];
   row_t              bank_row   [NUM_BANKS];
   logic [DATA_W-1:0] bank_wdata [NUM_BANKS];
   logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

   assign bank_lo = BANK_BITS'(bank_of(32'(io_addr_lo), BYTE_BITS, BANK_BITS));
   assign bank_hi = BANK_BITS'(bank_of(32'(io_addr_hi), BYTE_BITS, BANK_BITS));
   assign row_lo  = ROW_BITS'(row_of(32'(io_addr_lo), BYTE_BITS, BANK_BITS));
   assign row_hi  = ROW_BITS'(row_of(32'(io_addr_hi), BYTE_BITS, BANK_BITS));

   // Write wins when both flags are set.
   assign do_wr    = io_wren;
   assign do_rd    = io_rden & ~io_wren;
   assign accept   = io_req_valid & (state == RUN);
   assign conflict = (bank_lo == bank_hi) && (row_lo != row_hi);

   assign io_req_ready = (state == RUN);
   assign io_rd_valid  = rsp_valid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= INIT;
         scrub_row    <= '0;
         io_init_done <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == INIT) scrub_row <= scrub_row + 1'b1;
         if (state == RUN)  io_init_done <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (scrub_row == row_t'(DEPTH - 1)) state_nxt = RUN;
         RUN:     if (accept && conflict) state_nxt = SECOND;
         SECOND:  state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   // Same-bank requests always go to lo; hi only gets its own bank when the banks differ.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_en[b]    = 1'b0;
         bank_we[b]    = 1'b0;
         bank_row[b]   = '0;
         bank_wdata[b] = '0;
         case (state)
            INIT: begin
               bank_en[b]  = 1'b1;
               bank_we[b]  = 1'b1;
               bank_row[b] = scrub_row;
            end
            RUN: begin
               if (io_req_valid && bank_lo == bank_t'(b)) begin
                  bank_en[b]    = do_wr | do_rd;
                  bank_we[b]    = do_wr;
                  bank_row[b]   = row_lo;
                  bank_wdata[b] = io_wr_data_lo;
               end else if (io_req_valid && bank_hi == bank_t'(b)) begin
                  bank_en[b]    = do_wr | do_rd;
                  bank_we[b]    = do_wr;
                  bank_row[b]   = row_hi;
                  bank_wdata[b] = io_wr_data_hi;
               end
            end
            SECOND: begin
               if (hold_bank == bank_t'(b)) begin
                  bank_en[b]    = hold_wr | hold_rd;
                  bank_we[b]    = hold_wr;
                  bank_row[b]   = hold_row;
                  bank_wdata[b] = hold_data;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      dccm_sram_bank #(
         .DEPTH    (DEPTH),
         .ROW_BITS (ROW_BITS),
         .DATA_W   (DATA_W)
      ) u_bank (
         .clock (clock),
         .en    (bank_en[b]),
         .we    (bank_we[b]),
         .row   (bank_row[b]),
         .wdata (bank_wdata[b]),
         .rdata (bank_rdata[b])
      );
   end

   // A conflicting read parks its lo word in held_lo before the hi read overwrites that bank's output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_bank   <= '0;
         hold_row    <= '0;
         hold_data   <= '0;
         hold_wr     <= 1'b0;
         hold_rd     <= 1'b0;
         rsp_valid   <= 1'b0;
         lo_live     <= 1'b0;
         cap_pending <= 1'b0;
         lo_sel      <= '0;
         hi_sel      <= '0;
         held_lo     <= '0;
         held_hi     <= '0;
      end else begin
         rsp_valid   <= 1'b0;
         cap_pending <= 1'b0;
         if (accept) begin
            lo_sel      <= bank_lo;
            hi_sel      <= bank_hi;
            lo_live     <= ~conflict;
            rsp_valid   <= do_rd & ~conflict;
            cap_pending <= do_rd & conflict;
            if (conflict) begin
               hold_bank <= bank_hi;
               hold_row  <= row_hi;
               hold_data <= io_wr_data_hi;
               hold_wr   <= do_wr;
               hold_rd   <= do_rd;
            end
         end
         if (state == SECOND) rsp_valid <= hold_rd;
         if (rsp_valid) begin
            held_lo <= io_rd_data_lo;
            held_hi <= io_rd_data_hi;
         end else if (cap_pending) begin
            held_lo <= bank_rdata[lo_sel];
         end
      end
   end

   assign io_rd_data_lo = (rsp_valid && lo_live) ? bank_rdata[lo_sel] : held_lo;
   assign io_rd_data_hi = rsp_valid ? bank_rdata[hi_sel] : held_hi;

endmodule

// File: tb/tb_dccm_banked_mem.sv
// tb/tb_dccm_banked_mem.sv - self-checking bench for dccm_banked_mem with directed and randomized traffic
module tb_dccm_banked_mem;

   localparam int ADDR_BITS = 16;
   localparam int DATA_W    = 39;
   localparam int DEPTH     = 4096;

   logic                 clock, reset;
   logic                 io_req_valid, io_req_ready, io_wren, io_rden;
   logic [ADDR_BITS-1:0] io_addr_lo, io_addr_hi;
   logic [DATA_W-1:0]    io_wr_data_lo, io_wr_data_hi, io_rd_data_lo, io_rd_data_hi;
   logic                 io_rd_valid, io_init_done;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int                due;
      logic [DATA_W-1:0] lo;
      logic [DATA_W-1:0] hi;
   } rsp_t;

   dccm_banked_mem dut (
      .clock         (clock),
      .reset         (reset),
      .io_req_valid  (io_req_valid),
      .io_req_ready  (io_req_ready),
      .io_wren       (io_wren),
      .io_rden       (io_rden),
      .io_addr_lo    (io_addr_lo),
      .io_addr_hi    (io_addr_hi),
      .io_wr_data_lo (io_wr_data_lo),
      .io_wr_data_hi (io_wr_data_hi),
      .io_rd_valid   (io_rd_valid),
      .io_rd_data_lo (io_rd_data_lo),
      .io_rd_data_hi (io_rd_data_hi),
      .io_init_done  (io_init_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic idle_inputs();
      io_req_valid  = 1'b0;
      io_wren       = 1'b0;
      io_rden       = 1'b0;
      io_addr_lo    = '0;
      io_addr_hi    = '0;
      io_wr_data_lo = '0;
      io_wr_data_hi = '0;
   endtask

   // Called at a negedge with reset high; counts cycles until the first ready.
   task automatic release_and_scrub(output int low, output logic init_at, output logic init_next,
                                    output logic saw_rsp);
      low     = 0;
      saw_rsp = 1'b0;
      reset   = 1'b0;
      while (io_req_ready !== 1'b1 && low < DEPTH + 20) begin
         if (io_rd_valid !== 1'b0) saw_rsp = 1'b1;
         @(negedge clock);
         low++;
      end
      init_at = io_init_done;
      @(negedge clock);
      init_next = io_init_done;
   endtask

   // Issues one request and watches four cycles for the response; lat = -1 if never accepted.
   task automatic send(input logic wr, input logic rd, input logic [ADDR_BITS-1:0] alo,
                       input logic [ADDR_BITS-1:0] ahi, input logic [DATA_W-1:0] dlo,
                       input logic [DATA_W-1:0] dhi, output int lat, output int npulse,
                       output logic rdy_t1, output logic [DATA_W-1:0] qlo,
                       output logic [DATA_W-1:0] qhi);
      int w;
      lat = 0; npulse = 0; rdy_t1 = 1'b0; qlo = '0; qhi = '0; w = 0;
      while (io_req_ready !== 1'b1 && w < 10) begin
         @(negedge clock);
         w++;
      end
      if (io_req_ready !== 1'b1) begin
         lat = -1;
         return;
      end
      io_req_valid = 1'b1; io_wren = wr; io_rden = rd;
      io_addr_lo = alo; io_addr_hi = ahi; io_wr_data_lo = dlo; io_wr_data_hi = dhi;
      @(negedge clock);
      idle_inputs();
      rdy_t1 = io_req_ready;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) @(negedge clock);
         if (io_rd_valid === 1'b1) begin
            npulse++;
            if (lat == 0) begin
               lat = k; qlo = io_rd_data_lo; qhi = io_rd_data_hi;
            end
         end
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      tests++; if (io_req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", io_req_ready); end
      tests++; if (io_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", io_rd_valid); end
      tests++; if (io_rd_data_lo !== '0) begin fails++; $display("FAIL reset_data_lo: got %h want 0", io_rd_data_lo); end
      tests++; if (io_rd_data_hi !== '0) begin fails++; $display("FAIL reset_data_hi: got %h want 0", io_rd_data_hi); end
      tests++; if (io_init_done !== 1'b0) begin fails++; $display("FAIL reset_init_done: got %b want 0", io_init_done); end
   endtask

   task automatic test_scrub();
      int low, lat, np;
      logic ia, inx, saw, r1;
      logic [DATA_W-1:0] qlo, qhi;
      io_req_valid = 1'b1;
      release_and_scrub(low, ia, inx, saw);
      idle_inputs();
      tests++; if (low != DEPTH) begin fails++; $display("FAIL scrub_ready_low_cycles: got %0d want %0d", low, DEPTH); end
      tests++; if (ia !== 1'b0) begin fails++; $display("FAIL scrub_init_done_at_ready: got %b want 0", ia); end
      tests++; if (inx !== 1'b1) begin fails++; $display("FAIL scrub_init_done_next: got %b want 1", inx); end
      tests++; if (saw !== 1'b0) begin fails++; $display("FAIL scrub_spurious_rd_valid: got %b want 0", saw); end
      send(1'b0, 1'b1, 16'h0010, 16'h0014, '0, '0, lat, np, r1, qlo, qhi);
      tests++; if (lat != 1) begin fails++; $display("FAIL scrub_read_latency: got %0d want 1", lat); end
      tests++; if (qlo !== '0 || qhi !== '0) begin fails++; $display("FAIL scrub_read_data: got %h/%h want 0/0", qlo, qhi); end
   endtask

   task automatic test_noconflict();
      io_req_valid = 1'b1; io_wren = 1'b1; io_rden = 1'b0;
      io_addr_lo = 16'h0000; io_addr_hi = 16'h0004;
      io_wr_data_lo = 39'h12345678AB; io_wr_data_hi = 39'h0ABCDEF012;
      tests++; if (io_req_ready !== 1'b1) begin fails++; $display("FAIL nc_ready: got %b want 1", io_req_ready); end
      @(negedge clock);
      io_wren = 1'b0; io_rden = 1'b1; io_wr_data_lo = '0; io_wr_data_hi = '0;
      tests++; if (io_rd_valid !== 1'b0) begin fails++; $display("FAIL nc_write_no_rsp: got %b want 0", io_rd_valid); end
      @(negedge clock);
      idle_inputs();
      tests++; if (io_rd_valid !== 1'b1) begin fails++; $display("FAIL nc_rd_valid_t1: got %b want 1", io_rd_valid); end
      tests++; if (io_rd_data_lo !== 39'h12345678AB) begin fails++; $display("FAIL nc_data_lo: got %h want 12345678ab", io_rd_data_lo); end
      tests++; if (io_rd_data_hi !== 39'h0ABCDEF012) begin fails++; $display("FAIL nc_data_hi: got %h want 0abcdef012", io_rd_data_hi); end
      @(negedge clock);
      tests++; if (io_rd_valid !== 1'b0) begin fails++; $display("FAIL nc_single_pulse: got %b want 0", io_rd_valid); end
      tests++; if (io_rd_data_lo !== 39'h12345678AB) begin fails++; $display("FAIL nc_data_hold: got %h want 12345678ab", io_rd_data_lo); end
   endtask

   task automatic test_conflict();
      int lat, np;
      logic r1;
      logic [DATA_W-1:0] qlo, qhi;
      send(1'b1, 1'b0, 16'h0000, 16'h0010, 39'h11, 39'h22, lat, np, r1, qlo, qhi);
      tests++; if (r1 !== 1'b0) begin fails++; $display("FAIL cf_write_ready_t1: got %b want 0", r1); end
      tests++; if (np != 0) begin fails++; $display("FAIL cf_write_no_rsp: got %0d want 0", np); end
      send(1'b0, 1'b1, 16'h0000, 16'h0010, '0, '0, lat, np, r1, qlo, qhi);
      tests++; if (lat != 2) begin fails++; $display("FAIL cf_read_latency: got %0d want 2", lat); end
      tests++; if (np != 1) begin fails++; $display("FAIL cf_read_pulses: got %0d want 1", np); end
      tests++; if (qlo !== 39'h11 || qhi !== 39'h22) begin fails++; $display("FAIL cf_read_data: got %h/%h want 11/22", qlo, qhi); end
      tests++; if (io_rd_data_lo !== 39'h11 || io_rd_data_hi !== 39'h22) begin fails++; $display("FAIL cf_data_hold: got %h/%h want 11/22", io_rd_data_lo, io_rd_data_hi); end
   endtask

   task automatic test_same_row();
      int lat, np;
      logic r1;
      logic [DATA_W-1:0] qlo, qhi;
      send(1'b1, 1'b0, 16'h0008, 16'h0008, 39'h33, 39'h44, lat, np, r1, qlo, qhi);
      tests++; if (r1 !== 1'b1) begin fails++; $display("FAIL sr_no_stall: got %b want 1", r1); end
      send(1'b0, 1'b1, 16'h0008, 16'h000B, '0, '0, lat, np, r1, qlo, qhi);
      tests++; if (lat != 1) begin fails++; $display("FAIL sr_read_latency: got %0d want 1", lat); end
      tests++; if (qlo !== 39'h33 || qhi !== 39'h33) begin fails++; $display("FAIL sr_read_data: got %h/%h want 33/33", qlo, qhi); end
   endtask

   task automatic test_wren_rden();
      int lat, np;
      logic r1;
      logic [DATA_W-1:0] qlo, qhi;
      send(1'b1, 1'b1, 16'h0020, 16'h0020, 39'h55, 39'h66, lat, np, r1, qlo, qhi);
      tests++; if (np != 0) begin fails++; $display("FAIL wr_rd_no_rsp: got %0d want 0", np); end
      send(1'b0, 1'b0, 16'h0020, 16'h0024, 39'h99, 39'h99, lat, np, r1, qlo, qhi);
      tests++; if (np != 0 || lat != 0) begin fails++; $display("FAIL noop_no_rsp: got %0d want 0", np); end
      send(1'b0, 1'b1, 16'h0020, 16'h0024, '0, '0, lat, np, r1, qlo, qhi);
      tests++; if (lat != 1) begin fails++; $display("FAIL wr_rd_read_latency: got %0d want 1", lat); end
      tests++; if (qlo !== 39'h55 || qhi !== '0) begin fails++; $display("FAIL wr_rd_read_data: got %h/%h want 55/0", qlo, qhi); end
   endtask

   // Word-addressed reference memory; conflicts are same bank (word % 4) but different word.
   task automatic test_back_to_back();
      logic [DATA_W-1:0] model [0:31];
      rsp_t q[$];
      rsp_t r;
      int low, wlo, whi;
      logic ia, inx, saw, v, wr, rd, second, cf;
      logic [DATA_W-1:0] dlo, dhi;
      reset = 1'b1;
      @(negedge clock);
      release_and_scrub(low, ia, inx, saw);
      tests++; if (low != DEPTH) begin fails++; $display("FAIL b2b_scrub: got %0d want %0d", low, DEPTH); end
      for (int i = 0; i < 32; i++) model[i] = '0;
      second = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            tests++;
            if (io_rd_valid !== 1'b1 || io_rd_data_lo !== r.lo || io_rd_data_hi !== r.hi) begin
               fails++;
               $display("FAIL b2b_rsp cyc %0d: got v=%b %h/%h want v=1 %h/%h", cyc, io_rd_valid, io_rd_data_lo, io_rd_data_hi, r.lo, r.hi);
            end
         end else begin
            tests++; if (io_rd_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_rsp cyc %0d: got %b want 0", cyc, io_rd_valid); end
         end
         tests++; if (io_req_ready !== !second) begin fails++; $display("FAIL b2b_ready cyc %0d: got %b want %b", cyc, io_req_ready, !second); end
         if (second) begin
            second = 1'b0;
         end else if (cyc < 590) begin
            v  = ($urandom_range(0, 7) != 0);
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            wlo = int'($urandom_range(0, 31));
            whi = int'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) whi = (wlo + 4 * int'($urandom_range(1, 7))) % 32;
            dlo = 39'({$urandom(), $urandom()});
            dhi = 39'({$urandom(), $urandom()});
            io_req_valid = v; io_wren = wr; io_rden = rd;
            io_addr_lo = 16'(wlo * 4 + int'($urandom_range(0, 3)));
            io_addr_hi = 16'(whi * 4 + int'($urandom_range(0, 3)));
            io_wr_data_lo = dlo; io_wr_data_hi = dhi;
            if (v) begin
               cf = (wlo % 4 == whi % 4) && (wlo != whi);
               if (wr) begin
                  model[wlo] = dlo;
                  if (whi != wlo) model[whi] = dhi;
               end else if (rd) begin
                  q.push_back('{cyc + (cf ? 2 : 1), model[wlo], model[whi]});
               end
               second = cf;
            end
         end else begin
            idle_inputs();
         end
         @(negedge clock);
      end
      idle_inputs();
      tests++; if (q.size() != 0) begin fails++; $display("FAIL b2b_missing_rsp: got %0d pending want 0", q.size()); end
   endtask

   task automatic test_reset_mid_conflict();
      int lat, np, low;
      logic r1, ia, inx, saw, saw2;
      logic [DATA_W-1:0] qlo, qhi;
      send(1'b1, 1'b0, 16'h0000, 16'h0010, 39'h77, 39'h88, lat, np, r1, qlo, qhi);
      send(1'b0, 1'b1, 16'h0000, 16'h0010, '0, '0, lat, np, r1, qlo, qhi);
      tests++; if (lat != 2 || qlo !== 39'h77 || qhi !== 39'h88) begin fails++; $display("FAIL rmc_pre_read: got lat %0d %h/%h want 2 77/88", lat, qlo, qhi); end
      io_req_valid = 1'b1; io_rden = 1'b1; io_addr_lo = 16'h0000; io_addr_hi = 16'h0010;
      @(negedge clock);
      idle_inputs();
      tests++; if (io_req_ready !== 1'b0) begin fails++; $display("FAIL rmc_in_second: got %b want 0", io_req_ready); end
      #1 reset = 1'b1;
      #1;
      tests++; if (io_req_ready !== 1'b0 || io_rd_valid !== 1'b0 || io_init_done !== 1'b0) begin fails++; $display("FAIL rmc_ctrl_zero: got rdy=%b v=%b init=%b want 0/0/0", io_req_ready, io_rd_valid, io_init_done); end
      tests++; if (io_rd_data_lo !== '0 || io_rd_data_hi !== '0) begin fails++; $display("FAIL rmc_data_zero: got %h/%h want 0/0", io_rd_data_lo, io_rd_data_hi); end
      saw = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (io_rd_valid !== 1'b0) saw = 1'b1;
      end
      release_and_scrub(low, ia, inx, saw2);
      tests++; if (low != DEPTH) begin fails++; $display("FAIL rmc_full_scrub: got %0d want %0d", low, DEPTH); end
      tests++; if ((saw | saw2) !== 1'b0) begin fails++; $display("FAIL rmc_dropped_rsp: got %b want 0", saw | saw2); end
      send(1'b0, 1'b1, 16'h0000, 16'h0010, '0, '0, lat, np, r1, qlo, qhi);
      tests++; if (lat != 2 || qlo !== '0 || qhi !== '0) begin fails++; $display("FAIL rmc_post_read: got lat %0d %h/%h want 2 0/0", lat, qlo, qhi); end
   endtask

   initial begin
      test_reset();
      test_scrub();
      test_noconflict();
      test_conflict();
      test_same_row();
      test_wren_rden();
      test_back_to_back();
      test_reset_mid_conflict();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dccm_banked_mem.md
# dccm_banked_mem

Parametrised, banked, single-clock data-closely-coupled memory: the next-generation DCCM array behind the core memory wrapper. Width, bank count and depth are parameters. Adds what the fixed-geometry DCCM lacks: a valid/ready request handshake, same-bank lo/hi conflict serialisation, a post-reset zero-scrub sequencer, and a flagged read-response pipeline. It sits between the load/store unit's DCCM control and the physical SRAM banks.

## Interface
- ADDR_BITS, 16, byte-address width of the DCCM region
- DATA_W, 39, stored word width: 32 data + 7 ECC bits. ECC is opaque to this block.
- BYTE_BITS, 2, log2 bytes per word
- NUM_BANKS, 4, power of two, ≥2
- BANK_BITS, log2(NUM_BANKS), derived
- DEPTH, 2^(ADDR_BITS−BYTE_BITS−BANK_BITS), derived; rows per bank
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- io_req_valid  in  1  request present
- io_req_ready  out  1  request accepted when valid & ready
- io_wren  in  1  write request; has priority over io_rden
- io_rden  in  1  read request
- io_addr_lo / io_addr_hi  in  ADDR_BITS  byte addresses of the lo and hi words
- io_wr_data_lo / io_wr_data_hi  in  DATA_W  write data
- io_rd_valid  out  1  read response strobe, single cycle
- io_rd_data_lo / io_rd_data_hi  out  DATA_W  read response data
- io_init_done  out  1  scrub complete

## Operation
- **Address decode:**
  - bank = addr[BYTE_BITS +: BANK_BITS]
  - row = addr[ADDR_BITS−1 : BYTE_BITS+BANK_BITS]
  - addr[BYTE_BITS−1:0] is ignored.
- **FSM states:**
  - **INIT** (entered on reset): a row counter 0..DEPTH−1 writes zero to that row of every bank each cycle. At DEPTH−1 the FSM goes to RUN and io_init_done rises the next cycle, then stays 1 until reset. io_req_ready = 0.
  - **RUN**: io_req_ready = 1.
    - lo and hi in different banks: both accessed in the accept cycle.
    - Same bank and same row: one access. A read returns the same word on both lanes. A write stores io_wr_data_lo.
    - Same bank, different row (conflict): lo is accessed in the accept cycle; the hi address and data are latched and the FSM goes to SECOND.
  - **SECOND**: the latched hi access is performed, io_req_ready = 0, then the FSM returns to RUN.
- **Write vs read:**
  - io_wren & io_rden in the same request: executed as a write only; no read response.
  - A request with neither flag set is accepted and has no effect.
- **Read response:**
  - io_rd_valid pulses once per read request, after both lanes have completed.
  - rd_data holds its value until the next response.
  - No response backpressure.
- **Write→read ordering:** a read accepted in the cycle after a write to the same row returns the new data. The SRAM write completes before the next read, so no bypass is needed.
- **Reset mid-operation:** any in-flight request or response is dropped, the FSM returns to INIT and the scrub restarts from row 0.
- **Outputs during and after reset:**
  - io_req_ready = 0
  - io_rd_valid = 0
  - io_rd_data_lo / io_rd_data_hi = 0
  - io_init_done = 0

## Timing
- Non-conflict read: accept in cycle T; io_rd_valid and data in T+1.
- Conflict read: accept in T; hi access in T+1 with io_req_ready = 0; io_rd_valid in T+2.
- Writes: data visible to a read accepted in T+1.
- Throughput: one request per cycle without conflicts; one per two cycles with conflicts.
- Scrub: DEPTH cycles from reset deassertion to the first io_req_ready = 1. io_init_done is 1 from cycle DEPTH+1.
- io_req_ready is a registered function of the FSM state only; it has no combinational path from io_req_valid.

## Structure
- **Shared package `dccm_pkg`:**
  - state enum {INIT, RUN, SECOND}
  - functions bank_of(addr) and row_of(addr)
  - defaults for DATA_W and BYTE_BITS
- **Sub-module `dccm_sram_bank`:**
  - single-port synchronous RAM, DEPTH × DATA_W
  - inputs: en, we, row, wdata; output: rdata
  - registered read; no reset on the array
  - instantiated NUM_BANKS times
- **Top level holds:** bank-steering muxes, the conflict latch, the FSM, the scrub counter and the response-valid pipeline.
- Target size: 200–300 lines of RTL.

## Test plan
- **Scrub:** reset, then hold io_req_valid = 1. Expect io_req_ready = 0 for exactly DEPTH cycles, then 1. A read of addr 0x0010 / 0x0014 returns 0 / 0.
- **Non-conflict access:** write lo = 0x0000 data 0x12345678AB, hi = 0x0004 data 0x0ABCDEF012. A read of the same addresses in the next cycle gives rd_valid in T+1 with matching data.
- **Conflict:** write lo = 0x0000 data 0x11, hi = 0x0010 data 0x22 (same bank, different row). Expect io_req_ready = 0 in T+1. A read back gives rd_valid in T+2 with lo = 0x11 and hi = 0x22.
- **Same bank, same row:** write lo = hi = 0x0008, lo data 0x33, hi data 0x44. A read of 0x0008 on both lanes returns 0x33 on both.
- **wren & rden together:** write 0x55 to 0x0020 with both flags set. Expect no rd_valid; a later read returns 0x55.
- **Reset mid-conflict:** assert reset during SECOND. Expect outputs zero immediately, no rd_valid, and a full scrub; a later read of the conflicted address returns 0.
